// File: rtl/core_rc_pkg.sv
// core_rc_pkg: shared widths, FSM state type and leading-zero count for core_rc_scale_gen.
// The optional epsilon input is controlled by CORE_RC_SCALE_EPS_EN.
package core_rc_pkg;
   localparam int DW = 24;
   localparam int SW = 24;
   localparam int SHW = 5;
   localparam int LMAX = 12;
   localparam int ACC_W = 2*DW+LMAX;
   localparam int MS_W = 2*DW;
   typedef enum logic [2:0] {IDLE, ACC, SQRT, NORM, DIV, EMIT} state_e;
   function automatic logic [4:0] lzc(input logic [DW-1:0] v);
      logic [4:0] n;
      logic f;
      n = '0;
      f = 1'b0;
      for (int i = DW-1; i >= 0; i--) begin
         if (v[i]) f = 1'b1;
         else if (!f) n = n + 5'd1;
      end
      return n;
   endfunction
endpackage

// File: rtl/core_rc_scale_gen_if.sv
// core_rc_scale_gen_if: activation stream in, scale/shift out; cfg_eps exists only with CORE_RC_SCALE_EPS_EN.
interface core_rc_scale_gen_if import core_rc_pkg::*;;
   logic recompute_needed;
   logic [3:0] cfg_len_log2;
   logic [DW-1:0] in_data;
   logic in_data_vld;
   logic in_rdy;
   logic [SW-1:0] rc_scale;
   logic rc_scale_vld;
   logic rc_scale_clear;
   logic [SHW-1:0] rms_rc_shift;
   logic error;
`ifdef CORE_RC_SCALE_EPS_EN
   logic [DW-1:0] cfg_eps;
`endif
   modport master(
`ifdef CORE_RC_SCALE_EPS_EN
      output cfg_eps,
`endif
      output recompute_needed, cfg_len_log2, in_data, in_data_vld,
      input in_rdy, rc_scale, rc_scale_vld, rc_scale_clear, rms_rc_shift, error);
   modport slave(
`ifdef CORE_RC_SCALE_EPS_EN
      input cfg_eps,
`endif
      input recompute_needed, cfg_len_log2, in_data, in_data_vld,
      output in_rdy, rc_scale, rc_scale_vld, rc_scale_clear, rms_rc_shift, error);
endinterface

// File: rtl/core_rc_isqrt.sv
// core_rc_isqrt: restoring integer square root, one root bit per cycle; done pulses after the last bit.
module core_rc_isqrt import core_rc_pkg::*; (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic [MS_W-1:0] rad,
   output logic done,
   output logic [DW-1:0] root
);
   logic [MS_W-1:0] x_q, x_d;
   logic [DW:0] rem_q, rem_d;
   logic [DW-1:0] root_q, root_d;
   logic [4:0] cnt_q, cnt_d;
   logic busy_q, busy_d, done_q, done_d;
   logic [DW+2:0] rem_sh, trial;
   logic ge;
   always_comb begin
      rem_sh = {rem_q, x_q[MS_W-1 -: 2]};
      trial = {1'b0, root_q, 2'b01};
      ge = rem_sh >= trial;
      x_d = x_q;
      rem_d = rem_q;
      root_d = root_q;
      cnt_d = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (start && !busy_q) begin
         x_d = rad;
         rem_d = '0;
         root_d = '0;
         cnt_d = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         x_d = x_q << 2;
         rem_d = (DW+1)'(ge ? rem_sh - trial : rem_sh);
         root_d = {root_q[DW-2:0], ge};
         cnt_d = cnt_q + 5'd1;
         busy_d = cnt_q != 5'(DW-1);
         done_d = cnt_q == 5'(DW-1);
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q <= '0;
         rem_q <= '0;
         root_q <= '0;
         cnt_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         x_q <= x_d;
         rem_q <= rem_d;
         root_q <= root_d;
         cnt_q <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end
   assign done = done_q;
   assign root = root_q;
endmodule

// File: rtl/core_rc_scale_gen.sv
// core_rc_scale_gen: per-vector reciprocal RMS scale (rc_scale) and exponent (rms_rc_shift) for core_rc.
// CORE_RC_SCALE_EPS_EN adds cfg_eps to the mean square before the square root.
module core_rc_scale_gen import core_rc_pkg::*; (
   input logic clk,
   input logic rst,
   core_rc_scale_gen_if.slave bus
);
   state_e state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d, sq_ext;
   logic [15:0] cnt_q, cnt_d, cnt_inc;
   logic [3:0] len_q, len_d, cur_len;
   logic start_q, start_d, clear_q, clear_d, err_q, err_d, sat_q, sat_d;
   logic [DW-1:0] dvs_q, dvs_d, root, rms_n;
   logic [SW-1:0] rem_q, rem_d, scale_q, scale_d;
   logic [SW-2:0] quo_q, quo_d;
   logic [4:0] dcnt_q, dcnt_d, lz;
   logic [SHW-1:0] nsh_q, nsh_d, shift_q, shift_d;
   logic [MS_W-1:0] ms, rad;
   logic [SW:0] rem_sh;
   logic in_rdy, accept, last, done, ge;
   logic signed [MS_W-1:0] sq;
   assign ms = MS_W'(acc_q >> len_q);
`ifdef CORE_RC_SCALE_EPS_EN
   logic [MS_W:0] ms_sum;
   assign ms_sum = {1'b0, ms} + {{(MS_W-DW+1){1'b0}}, bus.cfg_eps};
   assign rad = ms_sum[MS_W] ? '1 : ms_sum[MS_W-1:0];
`else
   assign rad = ms;
`endif
   core_rc_isqrt u_isqrt (.clk(clk), .rst(rst), .start(start_q), .rad(rad), .done(done), .root(root));
   assign in_rdy = state_q == IDLE || state_q == ACC;
   assign accept = bus.in_data_vld && in_rdy && bus.recompute_needed;
   assign sq = $signed(bus.in_data) * $signed(bus.in_data);
   assign sq_ext = {{(ACC_W-MS_W){1'b0}}, sq};
   assign cur_len = state_q == IDLE ? bus.cfg_len_log2 : len_q;
   assign cnt_inc = (state_q == IDLE ? 16'd0 : cnt_q) + 16'd1;
   assign last = cnt_inc == (16'd1 << cur_len);
   assign lz = lzc(root);
   assign rms_n = root << lz;
   assign rem_sh = {rem_q, 1'b0};
   assign ge = rem_sh >= {1'b0, dvs_q};
   always_comb begin
      state_d = state_q;
      acc_d = acc_q;
      cnt_d = cnt_q;
      len_d = len_q;
      start_d = 1'b0;
      clear_d = 1'b0;
      err_d = err_q | (bus.in_data_vld & ~in_rdy);
      dvs_d = dvs_q;
      rem_d = rem_q;
      quo_d = quo_q;
      dcnt_d = dcnt_q;
      sat_d = sat_q;
      nsh_d = nsh_q;
      scale_d = scale_q;
      shift_d = shift_q;
      case (state_q)
         IDLE: if (accept) begin
            len_d = bus.cfg_len_log2;
            acc_d = sq_ext;
            cnt_d = 16'd1;
            clear_d = 1'b1;
            start_d = last;
            state_d = last ? SQRT : ACC;
         end
         ACC: if (!bus.recompute_needed) begin
            acc_d = '0;
            cnt_d = '0;
            state_d = IDLE;
         end else if (accept) begin
            acc_d = acc_q + sq_ext;
            cnt_d = cnt_inc;
            start_d = last;
            state_d = last ? SQRT : ACC;
         end
         SQRT: state_d = done ? NORM : SQRT;
         NORM: begin
            dvs_d = rms_n;
            rem_d = SW'(1) << (SW-1);
            quo_d = '0;
            dcnt_d = '0;
            // an exact power of two would need a 2^SW quotient, so it saturates like rms==0
            sat_d = root == '0 || rms_n == {1'b1, {(DW-1){1'b0}}};
            nsh_d = root == '0 ? '0 : 5'(DW-1) - lz;
            state_d = DIV;
         end
         DIV: begin
            rem_d = SW'(ge ? rem_sh - {1'b0, dvs_q} : rem_sh);
            quo_d = {quo_q[SW-3:0], ge};
            dcnt_d = dcnt_q + 5'd1;
            if (dcnt_q == 5'(SW-1)) begin
               scale_d = sat_q ? '1 : {quo_q, ge};
               shift_d = nsh_q;
               state_d = EMIT;
            end
         end
         EMIT: begin
            acc_d = '0;
            cnt_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q <= '0;
         cnt_q <= '0;
         len_q <= '0;
         start_q <= 1'b0;
         clear_q <= 1'b0;
         err_q <= 1'b0;
         dvs_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
         dcnt_q <= '0;
         sat_q <= 1'b0;
         nsh_q <= '0;
         scale_q <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         len_q <= len_d;
         start_q <= start_d;
         clear_q <= clear_d;
         err_q <= err_d;
         dvs_q <= dvs_d;
         rem_q <= rem_d;
         quo_q <= quo_d;
         dcnt_q <= dcnt_d;
         sat_q <= sat_d;
         nsh_q <= nsh_d;
         scale_q <= scale_d;
         shift_q <= shift_d;
      end
   end
   assign bus.in_rdy = in_rdy;
   assign bus.rc_scale = scale_q;
   assign bus.rc_scale_vld = state_q == EMIT;
   assign bus.rc_scale_clear = clear_q;
   assign bus.rms_rc_shift = shift_q;
   assign bus.error = err_q;
endmodule

// File: tb/tb_core_rc_scale_gen.sv
// tb_core_rc_scale_gen: table-driven vectors with a scoreboard of expected scale/shift/latency,
// plus hand-written overrun, abort and reset-during-DIV sequences.
module tb_core_rc_scale_gen;
   typedef struct {
      logic [3:0] len;
      logic [23:0] smp;
      logic [23:0] scale;
      logic [4:0] shift;
   } vec_t;
   typedef struct {
      logic [23:0] scale;
      logic [4:0] shift;
      int t;
   } exp_t;
   logic clk = 1'b0;
   logic rst;
   int cyc = 0;
   int total = 0;
   int pass = 0;
   int vld_cnt = 0;
   logic prev_vld = 1'b0;
   exp_t q[$];
   vec_t tbl[7];
   core_rc_scale_gen_if bus();
   core_rc_scale_gen dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
`ifdef CORE_RC_SCALE_EPS_EN
   initial bus.cfg_eps = '0;
`endif
   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act == exp) pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask
   always @(negedge clk) begin
      if (bus.rc_scale_vld) begin
         vld_cnt++;
         chk("vld_width", prev_vld, 0);
         if (q.size() == 0) chk("spurious_vld", 1, 0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("rc_scale", bus.rc_scale, e.scale);
            chk("rms_rc_shift", bus.rms_rc_shift, e.shift);
            chk("latency", cyc - e.t, 51);
         end
      end
      prev_vld = bus.rc_scale_vld;
   end
   task automatic send_vec(input logic [3:0] len, input logic [23:0] smp,
                           input logic [23:0] sc, input logic [4:0] sh);
      int n;
      exp_t e;
      n = 1 << len;
      bus.cfg_len_log2 = len;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == 1) chk("clear_pulse", bus.rc_scale_clear, 1);
         bus.in_data = smp;
         bus.in_data_vld = 1'b1;
      end
      @(negedge clk);
      if (n == 1) begin
         chk("clear_single", bus.rc_scale_clear, 1);
         chk("rdy_single", bus.in_rdy, 0);
      end
      bus.in_data_vld = 1'b0;
      e.scale = sc;
      e.shift = sh;
      e.t = cyc;
      q.push_back(e);
   endtask
   task automatic wait_idle();
      for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
      chk("drain_timeout", q.size(), 0);
      repeat (2) @(negedge clk);
   endtask
   initial begin
      int v0;
      tbl[0] = '{4'd2, 24'h000003, 24'hAAAAAA, 5'd1};
      tbl[1] = '{4'd2, 24'hFFFFFD, 24'hAAAAAA, 5'd1};
      tbl[2] = '{4'd2, 24'h000100, 24'hFFFFFF, 5'd8};
      tbl[3] = '{4'd1, 24'h000000, 24'hFFFFFF, 5'd0};
      tbl[4] = '{4'd0, 24'h000005, 24'hCCCCCC, 5'd2};
      tbl[5] = '{4'd3, 24'h7FFFFF, 24'h800001, 5'd22};
      tbl[6] = '{4'd0, 24'h800000, 24'hFFFFFF, 5'd23};
      rst = 1'b1;
      bus.recompute_needed = 1'b0;
      bus.cfg_len_log2 = '0;
      bus.in_data = '0;
      bus.in_data_vld = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_rdy", bus.in_rdy, 1);
      chk("rst_vld", bus.rc_scale_vld, 0);
      chk("rst_clear", bus.rc_scale_clear, 0);
      chk("rst_scale", bus.rc_scale, 0);
      chk("rst_shift", bus.rms_rc_shift, 0);
      chk("rst_error", bus.error, 0);
      rst = 1'b0;
      @(negedge clk);
      bus.recompute_needed = 1'b1;
      for (int k = 0; k < 7; k++) begin
         send_vec(tbl[k].len, tbl[k].smp, tbl[k].scale, tbl[k].shift);
         wait_idle();
      end
      chk("no_error", bus.error, 0);
      send_vec(4'd2, 24'h000003, 24'hAAAAAA, 5'd1);
      repeat (3) begin
         @(negedge clk);
         chk("overrun_rdy", bus.in_rdy, 0);
         bus.in_data = 24'h000100;
         bus.in_data_vld = 1'b1;
      end
      @(negedge clk);
      bus.in_data_vld = 1'b0;
      chk("overrun_err", bus.error, 1);
      wait_idle();
      chk("overrun_sticky", bus.error, 1);
      v0 = vld_cnt;
      bus.cfg_len_log2 = 4'd2;
      bus.in_data = 24'h000003;
      repeat (2) begin
         @(negedge clk);
         bus.in_data_vld = 1'b1;
      end
      @(negedge clk);
      bus.in_data_vld = 1'b0;
      bus.recompute_needed = 1'b0;
      @(negedge clk);
      bus.recompute_needed = 1'b1;
      repeat (70) @(negedge clk);
      chk("abort_no_vld", vld_cnt - v0, 0);
      chk("abort_no_error", bus.error, 1);
      send_vec(4'd2, 24'h000003, 24'hAAAAAA, 5'd1);
      wait_idle();
      send_vec(4'd2, 24'h000003, 24'hAAAAAA, 5'd1);
      repeat (35) @(negedge clk);
      chk("div_busy_rdy", bus.in_rdy, 0);
      v0 = vld_cnt;
      rst = 1'b1;
      #1;
      chk("rst_div_scale", bus.rc_scale, 0);
      chk("rst_div_shift", bus.rms_rc_shift, 0);
      chk("rst_div_vld", bus.rc_scale_vld, 0);
      chk("rst_div_error", bus.error, 0);
      chk("rst_div_rdy", bus.in_rdy, 1);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("rst_div_no_vld", vld_cnt - v0, 0);
      send_vec(4'd2, 24'h000003, 24'hAAAAAA, 5'd1);
      wait_idle();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
